// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared constants, FSM state type and line-address helper for the L1D bank
package l1_cache_pkg;

    localparam int ADDR_W = 64;
    localparam int TAG_W  = 24;
    localparam int IDX_W  = 6;
    localparam int OFF_W  = 6;
    localparam int WAY_W  = 3;
    localparam int BEATS  = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_TAGCHK,
        S_WB_REQ,
        S_WB_DATA,
        S_FILL_REQ,
        S_FILL_DATA,
        S_ACCESS,
        S_RESP
    } l1d_state_t;

    // Victim lines are rebuilt from tag and set only; bits above the tag are zero.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {{(ADDR_W-TAG_W-IDX_W-OFF_W){1'b0}}, tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1d_perf_counters.sv
// rtl/l1d_perf_counters.sv - saturating hit/miss/writeback event counters (used with L1D_PERF_CNT_EN)
module l1d_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hit_ev,
    input  logic        miss_ev,
    input  logic        wb_ev,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [31:0] perf_wbs
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            if (hit_ev && perf_hits != 32'hFFFF_FFFF)
                perf_hits <= perf_hits + 32'd1;
            if (miss_ev && perf_misses != 32'hFFFF_FFFF)
                perf_misses <= perf_misses + 32'd1;
            if (wb_ev && perf_wbs != 32'hFFFF_FFFF)
                perf_wbs <= perf_wbs + 32'd1;
        end
    end

endmodule

// File: rtl/l1d_miss_ctrl.sv
// rtl/l1d_miss_ctrl.sv - L1D request sequencer: lookup, hit access, writeback, refill, flush
// Optional perf counters via L1D_PERF_CNT_EN.
module l1d_miss_ctrl
    import l1_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic              cpu_req_clf,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_resp_valid,
    output logic              cpu_resp_hit,
    output logic              dp_lookup,
    output logic [IDX_W-1:0]  dp_index,
    output logic [TAG_W-1:0]  dp_tag,
    input  logic              dp_hit,
    input  logic [WAY_W-1:0]  dp_hit_way,
    input  logic [WAY_W-1:0]  dp_victim_way,
    input  logic              dp_victim_dirty,
    input  logic [TAG_W-1:0]  dp_victim_tag,
    output logic [WAY_W-1:0]  dp_way,
    output logic              dp_access,
    output logic [1:0]        dp_beat,
    output logic              dp_fill_we,
    output logic              dp_wb_rd,
    output logic              dp_tag_wr,
    output logic              dp_invalidate,
    output logic              lo_req_valid,
    input  logic              lo_req_ready,
    output logic              lo_req_write,
    output logic [ADDR_W-1:0] lo_req_addr,
    input  logic              lo_data_valid,
    input  logic              lo_wb_ready
`ifdef L1D_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses,
    output logic [31:0]       perf_wbs
`endif
);

    localparam int LINE_W = ADDR_W - OFF_W;

    l1d_state_t        state, state_d;
    logic [1:0]        count;
    logic [LINE_W-1:0] line_q;
    logic              we_q;
    logic              clf_q;
    logic              hit_q;
    logic [WAY_W-1:0]  way_q;
    logic [TAG_W-1:0]  vtag_q;
    logic              out_en;

    // The store/load distinction is carried out by the datapath during ACCESS.
    logic              unused_ok;
    assign unused_ok = &{1'b0, we_q, cpu_req_addr[OFF_W-1:0]};

    assign dp_index = line_q[IDX_W-1:0];
    assign dp_tag   = line_q[TAG_W+IDX_W-1:IDX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= 2'd0;
            line_q <= '0;
            we_q   <= 1'b0;
            clf_q  <= 1'b0;
            hit_q  <= 1'b0;
            way_q  <= '0;
            vtag_q <= '0;
            out_en <= 1'b0;
        end else begin
            state  <= state_d;
            out_en <= 1'b1;
            if (state == S_IDLE && cpu_req_valid && out_en) begin
                line_q <= cpu_req_addr[ADDR_W-1:OFF_W];
                we_q   <= cpu_req_we;
                clf_q  <= cpu_req_clf;
            end
            // A flushed dirty hit writes back its own line, so the victim tag is the request tag.
            if (state == S_TAGCHK) begin
                hit_q  <= dp_hit;
                way_q  <= dp_hit ? dp_hit_way : dp_victim_way;
                vtag_q <= dp_hit ? dp_tag : dp_victim_tag;
            end
            if ((state == S_WB_DATA && lo_wb_ready) || (state == S_FILL_DATA && lo_data_valid))
                count <= count + 2'd1;
        end
    end

    always_comb begin
        state_d        = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_hit   = 1'b0;
        dp_lookup      = 1'b0;
        dp_way         = way_q;
        dp_access      = 1'b0;
        dp_beat        = count;
        dp_fill_we     = 1'b0;
        dp_wb_rd       = 1'b0;
        dp_tag_wr      = 1'b0;
        dp_invalidate  = 1'b0;
        lo_req_valid   = 1'b0;
        lo_req_write   = 1'b0;
        lo_req_addr    = '0;
        case (state)
            S_IDLE: begin
                cpu_req_ready = out_en;
                if (cpu_req_valid && out_en)
                    state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                dp_lookup = 1'b1;
                state_d   = S_TAGCHK;
            end
            S_TAGCHK: begin
                dp_way = dp_hit ? dp_hit_way : dp_victim_way;
                if (clf_q) begin
                    if (!dp_hit)
                        state_d = S_RESP;
                    else if (dp_victim_dirty)
                        state_d = S_WB_REQ;
                    else begin
                        dp_invalidate = 1'b1;
                        state_d       = S_RESP;
                    end
                end else if (dp_hit)
                    state_d = S_ACCESS;
                else if (dp_victim_dirty)
                    state_d = S_WB_REQ;
                else
                    state_d = S_FILL_REQ;
            end
            S_WB_REQ: begin
                lo_req_valid = 1'b1;
                lo_req_write = 1'b1;
                lo_req_addr  = line_addr(vtag_q, dp_index);
                if (lo_req_ready)
                    state_d = S_WB_DATA;
            end
            S_WB_DATA: begin
                dp_wb_rd = 1'b1;
                if (lo_wb_ready && count == 2'd3) begin
                    if (clf_q) begin
                        dp_invalidate = 1'b1;
                        state_d       = S_RESP;
                    end else
                        state_d = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                lo_req_valid = 1'b1;
                lo_req_addr  = {line_q, {OFF_W{1'b0}}};
                if (lo_req_ready)
                    state_d = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                if (lo_data_valid) begin
                    dp_fill_we = 1'b1;
                    if (count == 2'd3) begin
                        dp_tag_wr = 1'b1;
                        state_d   = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                dp_access = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_hit   = hit_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef L1D_PERF_CNT_EN
    l1d_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .hit_ev      (state == S_TAGCHK && !clf_q && dp_hit),
        .miss_ev     (state == S_TAGCHK && !clf_q && !dp_hit),
        .wb_ev       (state == S_WB_REQ && lo_req_ready),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses),
        .perf_wbs    (perf_wbs)
    );
`endif

endmodule

// File: tb/tb_l1d_miss_ctrl.sv
// tb/tb_l1d_miss_ctrl.sv - directed self-checking bench for l1d_miss_ctrl
module tb_l1d_miss_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we, cpu_req_clf;
    logic [63:0] cpu_req_addr;
    logic        cpu_resp_valid, cpu_resp_hit;
    logic        dp_lookup;
    logic [5:0]  dp_index;
    logic [23:0] dp_tag;
    logic        dp_hit;
    logic [2:0]  dp_hit_way, dp_victim_way, dp_way;
    logic        dp_victim_dirty;
    logic [23:0] dp_victim_tag;
    logic        dp_access;
    logic [1:0]  dp_beat;
    logic        dp_fill_we, dp_wb_rd, dp_tag_wr, dp_invalidate;
    logic        lo_req_valid, lo_req_ready, lo_req_write;
    logic [63:0] lo_req_addr;
    logic        lo_data_valid, lo_wb_ready;
`ifdef L1D_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses, perf_wbs;
`endif

    l1d_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_clf(cpu_req_clf), .cpu_req_addr(cpu_req_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
        .dp_lookup(dp_lookup), .dp_index(dp_index), .dp_tag(dp_tag),
        .dp_hit(dp_hit), .dp_hit_way(dp_hit_way), .dp_victim_way(dp_victim_way),
        .dp_victim_dirty(dp_victim_dirty), .dp_victim_tag(dp_victim_tag),
        .dp_way(dp_way), .dp_access(dp_access), .dp_beat(dp_beat),
        .dp_fill_we(dp_fill_we), .dp_wb_rd(dp_wb_rd), .dp_tag_wr(dp_tag_wr),
        .dp_invalidate(dp_invalidate),
        .lo_req_valid(lo_req_valid), .lo_req_ready(lo_req_ready),
        .lo_req_write(lo_req_write), .lo_req_addr(lo_req_addr),
        .lo_data_valid(lo_data_valid), .lo_wb_ready(lo_wb_ready)
`ifdef L1D_PERF_CNT_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          r_resp_cyc, r_access_cyc, r_nfill, r_nwb, r_beat1_cyc;
    logic        r_resp_hit, r_tagwr_seen, r_tagwr_ok, r_lo_seen, r_inv_seen, r_beat_ok;
    logic        r_pre_rst, r_rst_zero;
    logic [2:0]  r_inv_way, r_access_way, r_fill_way;
    logic [63:0] r_wb_addr, r_fill_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic outs_zero();
        return ({cpu_req_ready, cpu_resp_valid, cpu_resp_hit, dp_lookup, dp_index, dp_tag,
                 dp_way, dp_access, dp_beat, dp_fill_we, dp_wb_rd, dp_tag_wr, dp_invalidate,
                 lo_req_valid, lo_req_write} == '0) && (lo_req_addr == 64'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from accept (cycle 0) to response; the lower cache accepts requests at
    // once and returns fill beats from the second cycle after accepting the fill request.
    task automatic run(input logic [63:0] a, input logic we, input logic clf,
                       input int stall_n, input int rst_at);
        int fill_acc, given, stall_left;
        fill_acc = -1; given = 0; stall_left = stall_n;
        r_resp_cyc = -1; r_access_cyc = -1; r_nfill = 0; r_nwb = 0; r_beat1_cyc = 0;
        r_resp_hit = 1'b0; r_tagwr_seen = 1'b0; r_tagwr_ok = 1'b0; r_lo_seen = 1'b0;
        r_inv_seen = 1'b0; r_beat_ok = 1'b1; r_inv_way = '0; r_access_way = '0;
        r_fill_way = '0; r_wb_addr = '0; r_fill_addr = '0; r_pre_rst = 1'b0; r_rst_zero = 1'b0;
        for (int c = 0; c < 60; c++) begin
            cpu_req_valid = (c == 0);
            cpu_req_we    = we;
            cpu_req_clf   = clf;
            cpu_req_addr  = a;
            lo_data_valid = (fill_acc >= 0) && (c >= fill_acc + 2) && (given < 4);
            if (lo_data_valid) given++;
            lo_wb_ready = 1'b1;
            if (dp_wb_rd && dp_beat == 2'd1) begin
                r_beat1_cyc++;
                if (stall_left > 0) begin
                    lo_wb_ready = 1'b0;
                    stall_left--;
                end
            end
            #1;
            if (c == rst_at) begin
                r_pre_rst = dp_fill_we && (dp_beat == 2'd2);
                rst_n = 1'b0;
                #1;
                r_rst_zero = outs_zero();
                cpu_req_valid = 1'b0;
                lo_data_valid = 1'b0;
                return;
            end
            if (lo_req_valid && lo_req_ready) begin
                r_lo_seen = 1'b1;
                if (lo_req_write) r_wb_addr = lo_req_addr;
                else begin
                    r_fill_addr = lo_req_addr;
                    fill_acc = c;
                end
            end
            if (dp_fill_we) begin
                if (dp_beat != r_nfill[1:0]) r_beat_ok = 1'b0;
                r_nfill++;
                r_fill_way = dp_way;
            end
            if (dp_tag_wr) begin
                r_tagwr_seen = 1'b1;
                r_tagwr_ok = dp_fill_we && (dp_beat == 2'd3);
            end
            if (dp_wb_rd && lo_wb_ready) begin
                if (dp_beat != r_nwb[1:0]) r_beat_ok = 1'b0;
                r_nwb++;
            end
            if (dp_invalidate) begin
                r_inv_seen = 1'b1;
                r_inv_way = dp_way;
            end
            if (dp_access) begin
                r_access_cyc = c;
                r_access_way = dp_way;
            end
            if (cpu_resp_valid) begin
                r_resp_cyc = c;
                r_resp_hit = cpu_resp_hit;
                break;
            end
            @(posedge clk);
            #1;
        end
        cpu_req_valid = 1'b0;
        lo_data_valid = 1'b0;
        tick();
    endtask

    task automatic set_dp(input logic hit, input logic [2:0] hw, input logic [2:0] vw,
                          input logic vd, input logic [23:0] vt);
        dp_hit = hit; dp_hit_way = hw; dp_victim_way = vw; dp_victim_dirty = vd; dp_victim_tag = vt;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_clf = 1'b0; cpu_req_addr = '0;
        lo_req_ready = 1'b1; lo_data_valid = 1'b0; lo_wb_ready = 1'b1;
        set_dp(1'b0, 3'd0, 3'd0, 1'b0, 24'd0);
        #3;
        chk("reset_outputs_zero", outs_zero(), 1'b1);
        tick();
        tick();
        chk("reset_ready_low", cpu_req_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ready_low_before_edge", cpu_req_ready, 1'b0);
        tick();
        chk("ready_after_release", cpu_req_ready, 1'b1);

        // Load hit, way 5
        set_dp(1'b1, 3'd5, 3'd1, 1'b1, 24'h777777);
        run(64'h0000_0000_0ABC_0040, 1'b0, 1'b0, 0, -1);
        chk("hit_access_cyc", r_access_cyc, 3);
        chk("hit_access_way", r_access_way, 5);
        chk("hit_resp_cyc", r_resp_cyc, 4);
        chk("hit_resp_hit", r_resp_hit, 1'b1);
        chk("hit_no_lower", r_lo_seen, 1'b0);
        chk("hit_index", dp_index, 6'd1);
        chk("hit_tag", dp_tag, 24'h00ABC0);
        chk("idle_ready", cpu_req_ready, 1'b1);

        // Store miss, clean victim way 2
        set_dp(1'b0, 3'd7, 3'd2, 1'b0, 24'h555555);
        run(64'h0000_0000_0ABC_0040, 1'b1, 1'b0, 0, -1);
        chk("cm_fill_addr", r_fill_addr, 64'h0000_0000_0ABC_0040);
        chk("cm_wb_addr", r_wb_addr, 64'd0);
        chk("cm_nfill", r_nfill, 4);
        chk("cm_beats", r_beat_ok, 1'b1);
        chk("cm_tagwr_ok", r_tagwr_ok, 1'b1);
        chk("cm_fill_way", r_fill_way, 2);
        chk("cm_resp_cyc", r_resp_cyc, 10);
        chk("cm_resp_hit", r_resp_hit, 1'b0);

        // Load miss, dirty victim tag 0x123456, beat 1 stalled 3 cycles
        set_dp(1'b0, 3'd0, 3'd3, 1'b1, 24'h123456);
        run(64'h0000_0000_0ABC_0040, 1'b0, 1'b0, 3, -1);
        chk("dm_wb_addr", r_wb_addr, 64'h0000_0001_2345_6040);
        chk("dm_nwb", r_nwb, 4);
        chk("dm_beat1_held", r_beat1_cyc, 4);
        chk("dm_fill_addr", r_fill_addr, 64'h0000_0000_0ABC_0040);
        chk("dm_nfill", r_nfill, 4);
        chk("dm_beats", r_beat_ok, 1'b1);
        chk("dm_resp_cyc", r_resp_cyc, 18);
        chk("dm_resp_hit", r_resp_hit, 1'b0);

        // CLF hit dirty, way 6
        set_dp(1'b1, 3'd6, 3'd1, 1'b1, 24'h111111);
        run(64'h0000_000F_EDCB_A9C0, 1'b0, 1'b1, 0, -1);
        chk("clfd_wb_addr", r_wb_addr, 64'h0000_000F_EDCB_A9C0);
        chk("clfd_nwb", r_nwb, 4);
        chk("clfd_nfill", r_nfill, 0);
        chk("clfd_inv", r_inv_seen, 1'b1);
        chk("clfd_inv_way", r_inv_way, 6);
        chk("clfd_resp_cyc", r_resp_cyc, 8);
        chk("clfd_resp_hit", r_resp_hit, 1'b1);

        // CLF miss
        set_dp(1'b0, 3'd0, 3'd4, 1'b1, 24'h222222);
        run(64'h0000_0000_0123_4580, 1'b0, 1'b1, 0, -1);
        chk("clfm_resp_cyc", r_resp_cyc, 3);
        chk("clfm_resp_hit", r_resp_hit, 1'b0);
        chk("clfm_no_lower", r_lo_seen, 1'b0);
        chk("clfm_no_inv", r_inv_seen, 1'b0);

        // CLF hit clean, way 4
        set_dp(1'b1, 3'd4, 3'd1, 1'b0, 24'h333333);
        run(64'h0000_0000_0123_4580, 1'b0, 1'b1, 0, -1);
        chk("clfc_resp_cyc", r_resp_cyc, 3);
        chk("clfc_inv_way", r_inv_way, 4);
        chk("clfc_resp_hit", r_resp_hit, 1'b1);
        chk("clfc_no_lower", r_lo_seen, 1'b0);

        // Reset during fill beat 2
        set_dp(1'b0, 3'd0, 3'd2, 1'b0, 24'h444444);
        run(64'h0000_0000_0ABC_0040, 1'b1, 1'b0, 0, 7);
        chk("rst_at_beat2", r_pre_rst, 1'b1);
        chk("rst_outputs_zero", r_rst_zero, 1'b1);
        chk("rst_no_tagwr", r_tagwr_seen, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready_again", cpu_req_ready, 1'b1);

        // Post-reset traffic: 3 hits, 2 misses (1 dirty)
        set_dp(1'b1, 3'd5, 3'd1, 1'b0, 24'h0);
        run(64'h0000_0000_0ABC_0040, 1'b0, 1'b0, 0, -1);
        chk("post_hit_resp_cyc", r_resp_cyc, 4);
        run(64'h0000_0000_0ABC_0080, 1'b1, 1'b0, 0, -1);
        run(64'h0000_0000_0ABC_00C0, 1'b0, 1'b0, 0, -1);
        chk("post_hit3_resp_hit", r_resp_hit, 1'b1);
        set_dp(1'b0, 3'd0, 3'd2, 1'b0, 24'h0);
        run(64'h0000_0000_0ABC_0100, 1'b0, 1'b0, 0, -1);
        chk("post_cm_resp_cyc", r_resp_cyc, 10);
        set_dp(1'b0, 3'd0, 3'd3, 1'b1, 24'h0000AB);
        run(64'h0000_0000_0ABC_0140, 1'b0, 1'b0, 0, -1);
        chk("post_dm_resp_cyc", r_resp_cyc, 15);
        chk("post_dm_wb_addr", r_wb_addr, 64'h0000_0000_000A_B140);
`ifdef L1D_PERF_CNT_EN
        chk("perf_hits", perf_hits, 3);
        chk("perf_misses", perf_misses, 2);
        chk("perf_wbs", perf_wbs, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1d_miss_ctrl.md
Name: l1d_miss_ctrl

Overview:
- Request sequencer for the L1 data cache bank.
- Accepts one CPU load, store or cache-line-flush (CLF) at a time and drives tag lookup, hit access, dirty-victim writeback, 4-beat line refill and invalidate on the bank datapath.
- Carries the lower-cache handshake toward L2.
- Single outstanding request; blocking.

Parameters:
- ADDR_W, 64, address width.
- TAG_W, 24, tag width; tag = addr[35:12].
- IDX_W, 6, set index; index = addr[11:6].
- OFF_W, 6, block offset; 64-byte line.
- WAY_W, 3, way select; 8-way.
- BEATS, 4, 128-bit beats per 512-bit line.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  request present.
- cpu_req_ready  out  1  high only in IDLE.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_req_clf  in  1  flush line; has priority over cpu_req_we.
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_hit  out  1  original lookup hit; valid with cpu_resp_valid.
- dp_lookup  out  1  tag compare on dp_index/dp_tag.
- dp_index  out  IDX_W  latched set index.
- dp_tag  out  TAG_W  latched tag.
- dp_hit  in  1  lookup hit; valid the cycle after dp_lookup.
- dp_hit_way  in  WAY_W  hit way.
- dp_victim_way  in  WAY_W  replacement choice.
- dp_victim_dirty  in  1  victim dirty bit.
- dp_victim_tag  in  TAG_W  victim tag.
- dp_way  out  WAY_W  way for access, fill, writeback and invalidate.
- dp_access  out  1  perform the read/write on dp_way.
- dp_beat  out  2  beat number for fill or writeback.
- dp_fill_we  out  1  write lo_data beat into dp_way.
- dp_wb_rd  out  1  present victim beat dp_beat on the lower write-data bus.
- dp_tag_wr  out  1  write tag, set valid, clear dirty on dp_way.
- dp_invalidate  out  1  clear valid and dirty on dp_way.
- lo_req_valid  out  1  line request to the lower cache.
- lo_req_ready  in  1  lower cache accepts.
- lo_req_write  out  1  1 = writeback, 0 = fill.
- lo_req_addr  out  ADDR_W  line-aligned address.
- lo_data_valid  in  1  fill beat present.
- lo_wb_ready  in  1  writeback beat accepted.

Behaviour:
- Reset:
  - All outputs 0 (including cpu_req_ready); state IDLE; beat counter 0; latches cleared. cpu_req_ready rises the first cycle after rst_n deasserts.
  - Reset mid-operation abandons the transaction; no partial line is marked valid.
- States: IDLE, LOOKUP, TAGCHK, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, ACCESS, RESP.
- IDLE:
  - cpu_req_ready=1.
  - On valid&ready, latch addr, we, clf -> LOOKUP.
- LOOKUP: dp_lookup=1 for one cycle -> TAGCHK.
- TAGCHK: sample dp_* and latch hit, way, victim info.
  - Load/store hit -> ACCESS, dp_way=hit_way.
  - Load/store miss: victim dirty -> WB_REQ, else FILL_REQ; dp_way=victim_way.
  - CLF hit dirty -> WB_REQ with the hit way as victim.
  - CLF hit clean -> RESP, dp_invalidate=1 that cycle.
  - CLF miss -> RESP.
- WB_REQ:
  - lo_req_valid=1, lo_req_write=1, lo_req_addr={28'b0, victim_tag, index, 6'b0}.
  - Address and valid held stable until lo_req_ready -> WB_DATA.
- WB_DATA:
  - dp_wb_rd=1 with dp_beat=count.
  - Count advances only on lo_wb_ready.
  - After beat 3 is accepted: count wraps to 0. CLF -> RESP with dp_invalidate=1 on exit. Load/store -> FILL_REQ.
- FILL_REQ: lo_req_valid=1, lo_req_write=0, lo_req_addr={addr[63:6], 6'b0}; held until lo_req_ready -> FILL_DATA.
- FILL_DATA:
  - Each lo_data_valid: dp_fill_we=1 with dp_beat=count, then increment.
  - On beat 3: dp_tag_wr=1 -> ACCESS.
  - lo_data_valid in any other state is ignored.
- ACCESS: dp_access=1 one cycle; the datapath performs the store (sets dirty) or load -> RESP.
- RESP: cpu_resp_valid=1 one cycle; cpu_resp_hit=latched hit -> IDLE. No CPU backpressure.
- Latency from accept (cycle 0):
  - Hit: resp at cycle 4.
  - Clean miss: 4 + fill handshake + 4 beats minimum, i.e. cycle 10 with zero-wait lower cache.
  - Dirty miss adds 5 cycles minimum.
- Beat counter: 2 bits, wraps 3->0. It is only written in WB_DATA and FILL_DATA.

Optional Feature:
L1D_PERF_CNT_EN:
- Present:
  - Adds 32-bit outputs perf_hits, perf_misses, perf_wbs, reset to 0.
  - Counters increment on the TAGCHK outcome (CLF excluded) and on WB_REQ acceptance; saturate at 0xFFFFFFFF.
- Absent: ports and logic removed; behaviour otherwise identical.

Decomposition:
- Package l1_cache_pkg:
  - TAG_W/IDX_W/OFF_W/WAY_W/BEATS constants.
  - l1d_state_t enum.
  - Line-address helper function.
- Sub-module l1d_perf_counters: instantiated only under L1D_PERF_CNT_EN.
- Main FSM and beat counter stay in one module.

Test Plan:
- Load addr 0x0000_0ABC_0040 with dp_hit=1, way 5 -> dp_way=5, dp_access at cycle 3, cpu_resp_valid with hit=1 at cycle 4, no lo_req_valid.
- Store miss, victim clean way 2, zero-wait lower cache -> fill lo_req_addr=0x…0040, 4 dp_fill_we beats 0..3, dp_tag_wr on beat 3, resp hit=0 at cycle 10.
- Load miss, victim dirty tag 0x123456, index 1 -> writeback lo_req_addr=0x0_1234_5604_0, 4 wb beats, then fill; lo_wb_ready stalled 3 cycles on beat 1 -> dp_beat holds 1.
- CLF hit dirty -> writeback then dp_invalidate pulse, resp hit=1. CLF miss -> resp hit=0 at cycle 3, no lower traffic.
- rst_n low during FILL_DATA beat 2 -> outputs 0 immediately, no dp_tag_wr; after release, a new request is accepted normally.
- With L1D_PERF_CNT_EN: 3 hits, 2 misses (1 dirty) -> perf_hits=3, perf_misses=2, perf_wbs=1.
